// File: rtl/fir_pkg.sv
// Shared constants and FSM encoding for the FIR result streamer.
package fir_pkg;

  localparam int LEN_DEFAULT             = 19;
  localparam int SIGNAL_LENGTH_1_DEFAULT = 2400;
  localparam int SAMPLE_W                = 16;
  localparam int INDEX_W                 = 12;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    STREAM,
    WAIT_LOW
  } state_t;

endpackage

// File: rtl/fir_sample_mux.sv
// Registered one-of-N sample selector; loads the slice addressed by sel when load is high.
module fir_sample_mux
  import fir_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [N*SAMPLE_W-1:0]      samples,
  input  logic [INDEX_W-1:0]         sel,
  output logic signed [SAMPLE_W-1:0] sample
);

  logic [SAMPLE_W-1:0] slice_arr [N];
  logic [N-1:0]        hit;
  logic [SAMPLE_W-1:0] picked;
  logic [SAMPLE_W-1:0] sample_reg;

  // One-hot decode keeps every bit of sel in play regardless of N.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slice
      assign slice_arr[gi] = samples[gi*SAMPLE_W +: SAMPLE_W];
      assign hit[gi]       = (sel == INDEX_W'(gi));
    end
  endgenerate

  always_comb begin
    picked = '0;
    for (int i = 0; i < N; i++) begin
      picked = picked | ({SAMPLE_W{hit[i]}} & slice_arr[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_reg <= '0;
    end else if (load) begin
      sample_reg <= picked;
    end
  end

  assign sample = sample_reg;

endmodule

// File: rtl/fir_result_streamer.sv
// Captures a packed block of convolution results on the rising edge of is_completed
// and streams them out one sample per accepted handshake.
module fir_result_streamer
  import fir_pkg::*;
#(
  parameter  int LEN             = LEN_DEFAULT,
  parameter  int SIGNAL_LENGTH_1 = SIGNAL_LENGTH_1_DEFAULT,
  parameter  int DROP_HEAD       = 0,
  localparam int TOTAL           = LEN + SIGNAL_LENGTH_1 + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic signed [TOTAL*SAMPLE_W:0]  flatten_conv_result,
  input  logic                            is_completed,
  output logic signed [SAMPLE_W-1:0]      sample_data,
  output logic                            sample_valid,
  input  logic                            sample_ready,
  output logic [INDEX_W-1:0]              sample_index,
  output logic                            sample_last,
  output logic                            busy,
  output logic                            done
);

  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(TOTAL - 1);
  localparam logic [INDEX_W-1:0] HEAD_IDX = INDEX_W'(DROP_HEAD);

  state_t                    state_reg, state_next;
  logic                      completed_d_reg;
  logic [TOTAL*SAMPLE_W-1:0] buffer_reg, buffer_next;
  logic [INDEX_W-1:0]        index_reg, index_next;
  logic                      valid_reg, valid_next;
  logic                      last_reg, last_next;
  logic                      done_reg, done_next;
  logic                      load;
  logic                      transfer;
  logic                      unused_msb;

  assign unused_msb = flatten_conv_result[TOTAL*SAMPLE_W];
  assign transfer   = valid_reg & sample_ready;

  // The mux sees the buffer contents that will exist after this edge, so the
  // first sample is ready in the same cycle the FSM enters STREAM.
  assign buffer_next = (state_reg == CAPTURE) ? flatten_conv_result[TOTAL*SAMPLE_W-1:0]
                                              : buffer_reg;

  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    valid_next = valid_reg;
    last_next  = last_reg;
    done_next  = 1'b0;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (is_completed && !completed_d_reg) state_next = CAPTURE;
      end
      CAPTURE: begin
        state_next = STREAM;
        index_next = HEAD_IDX;
        valid_next = 1'b1;
        last_next  = (HEAD_IDX == LAST_IDX);
        load       = 1'b1;
      end
      STREAM: begin
        if (transfer) begin
          if (last_reg) begin
            state_next = WAIT_LOW;
            valid_next = 1'b0;
            last_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            index_next = index_reg + 1'b1;
            last_next  = (index_next == LAST_IDX);
            load       = 1'b1;
          end
        end
      end
      WAIT_LOW: begin
        if (!is_completed) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      completed_d_reg <= 1'b1;
      index_reg       <= '0;
      valid_reg       <= 1'b0;
      last_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      completed_d_reg <= is_completed;
      index_reg       <= index_next;
      valid_reg       <= valid_next;
      last_reg        <= last_next;
      done_reg        <= done_next;
    end
  end

  always_ff @(posedge clk) begin
    buffer_reg <= buffer_next;
  end

  fir_sample_mux #(
    .N(TOTAL)
  ) u_sample_mux (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .samples(buffer_next),
    .sel    (index_next),
    .sample (sample_data)
  );

  assign sample_valid = valid_reg;
  assign sample_index = index_reg;
  assign sample_last  = last_reg;
  assign done         = done_reg;
  assign busy         = (state_reg == CAPTURE) || (state_reg == STREAM);

endmodule

// File: tb/tb_fir_result_streamer.sv
// Directed bench: three streamers (no drop, drop 3, drop to last) on shared stimulus.
module tb_fir_result_streamer;

  localparam int LEN   = 3;
  localparam int SL1   = 4;
  localparam int TOTAL = LEN + SL1 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 is_completed;
  logic                 sample_ready;
  logic [TOTAL*16:0]    flat;

  logic [15:0] data_a, data_h, data_t;
  logic [11:0] index_a, index_h, index_t;
  logic        valid_a, valid_h, valid_t;
  logic        last_a, last_h, last_t;
  logic        busy_a, busy_h, busy_t;
  logic        done_a, done_h, done_t;

  fir_result_streamer #(.LEN(LEN), .SIGNAL_LENGTH_1(SL1), .DROP_HEAD(0)) u_dut (
    .clk(clk), .rst(rst), .flatten_conv_result(flat), .is_completed(is_completed),
    .sample_data(data_a), .sample_valid(valid_a), .sample_ready(sample_ready),
    .sample_index(index_a), .sample_last(last_a), .busy(busy_a), .done(done_a)
  );

  fir_result_streamer #(.LEN(LEN), .SIGNAL_LENGTH_1(SL1), .DROP_HEAD(3)) u_dut_head (
    .clk(clk), .rst(rst), .flatten_conv_result(flat), .is_completed(is_completed),
    .sample_data(data_h), .sample_valid(valid_h), .sample_ready(sample_ready),
    .sample_index(index_h), .sample_last(last_h), .busy(busy_h), .done(done_h)
  );

  fir_result_streamer #(.LEN(LEN), .SIGNAL_LENGTH_1(SL1), .DROP_HEAD(TOTAL-1)) u_dut_tail (
    .clk(clk), .rst(rst), .flatten_conv_result(flat), .is_completed(is_completed),
    .sample_data(data_t), .sample_valid(valid_t), .sample_ready(sample_ready),
    .sample_index(index_t), .sample_last(last_t), .busy(busy_t), .done(done_t)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_flat(input bit ones);
    for (int k = 0; k < TOTAL; k++) flat[k*16 +: 16] = ones ? 16'hFFFF : 16'(100 + k);
    flat[TOTAL*16] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, valid_a, 0);
    check({tag, "_last"},  last_a,  0);
    check({tag, "_busy"},  busy_a,  0);
    check({tag, "_done"},  done_a,  0);
    check({tag, "_index"}, index_a, 0);
    check({tag, "_data"},  data_a,  0);
  endtask

  // Raise is_completed with ready held high and check the full 100..107 stream.
  task automatic stream_full(input bit with_drop);
    is_completed = 1'b1;
    tick();
    check("capture_busy", busy_a, 1);
    check("capture_no_valid", valid_a, 0);
    for (int k = 0; k < TOTAL; k++) begin
      tick();
      $display("xfer idx=%0d data=%0d last=%0b", index_a, data_a, last_a);
      check("full_valid", valid_a, 1);
      check("full_data", data_a, 100 + k);
      check("full_index", index_a, k);
      check("full_last", last_a, (k == TOTAL - 1) ? 1 : 0);
      if (with_drop) begin
        if (k < 5) begin
          check("head_valid", valid_h, 1);
          check("head_data", data_h, 103 + k);
          check("head_index", index_h, 3 + k);
          check("head_last", last_h, (k == 4) ? 1 : 0);
        end
        if (k == 5) begin
          check("head_done", done_h, 1);
          check("head_valid_drop", valid_h, 0);
        end
        if (k == 0) begin
          check("tail_valid", valid_t, 1);
          check("tail_data", data_t, 107);
          check("tail_index", index_t, 7);
          check("tail_last", last_t, 1);
        end
        if (k == 1) begin
          check("tail_done", done_t, 1);
          check("tail_valid_drop", valid_t, 0);
        end
      end
    end
    tick();
    check("full_done", done_a, 1);
    check("full_valid_drop", valid_a, 0);
    check("full_busy_drop", busy_a, 0);
    tick();
    check("full_done_one_cycle", done_a, 0);
  endtask

  initial begin
    int n_valid;
    int n_done;
    int exp_k;
    int guard;
    int phase;
    bit stalled;
    bit seen_done;
    bit prev_last_xfer;
    logic [15:0] held_data;
    logic [11:0] held_index;

    rst          = 1'b1;
    is_completed = 1'b1;
    sample_ready = 1'b1;
    load_flat(1'b0);
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    // A level already high at reset release must not start a stream.
    repeat (5) tick();
    check("stale_high_busy", busy_a, 0);
    check("stale_high_valid", valid_a, 0);
    is_completed = 1'b0;
    repeat (3) tick();

    stream_full(1'b1);

    // Completion held high: no re-trigger.
    n_valid = 0;
    n_done  = 0;
    repeat (50) begin
      tick();
      if (valid_a) n_valid++;
      if (done_a) n_done++;
    end
    check("held_high_no_valid", n_valid, 0);
    check("held_high_no_done", n_done, 0);
    is_completed = 1'b0;
    tick();
    tick();

    // Ready pattern 1,0,0 with the input bus overwritten once streaming starts.
    is_completed   = 1'b1;
    exp_k          = 0;
    guard          = 0;
    phase          = 0;
    stalled        = 1'b0;
    seen_done      = 1'b0;
    prev_last_xfer = 1'b0;
    held_data      = '0;
    held_index     = '0;
    tick();
    while (!seen_done && guard < 60) begin
      tick();
      guard++;
      sample_ready = (phase % 3 == 0);
      phase++;
      if (done_a || prev_last_xfer) check("stall_done_timing", done_a, prev_last_xfer);
      if (done_a) seen_done = 1'b1;
      prev_last_xfer = 1'b0;
      if (valid_a) begin
        load_flat(1'b1);
        if (stalled) begin
          check("stall_hold_data", data_a, held_data);
          check("stall_hold_index", index_a, held_index);
        end
        if (sample_ready) begin
          $display("xfer idx=%0d data=%0d last=%0b", index_a, data_a, last_a);
          check("stall_data", data_a, 100 + exp_k);
          check("stall_index", index_a, exp_k);
          check("stall_last", last_a, (exp_k == TOTAL - 1) ? 1 : 0);
          prev_last_xfer = (exp_k == TOTAL - 1);
          exp_k++;
          stalled = 1'b0;
        end else begin
          held_data  = data_a;
          held_index = index_a;
          stalled    = 1'b1;
        end
      end
    end
    check("stall_all_delivered", exp_k, TOTAL);
    check("stall_done_seen", seen_done, 1);
    check("stall_valid_after_done", valid_a, 0);
    sample_ready = 1'b1;
    is_completed = 1'b0;
    load_flat(1'b0);
    tick();
    tick();

    // Reset in the middle of a stream.
    is_completed = 1'b1;
    tick();
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!(valid_a && index_a == 12'd4) && guard < 10);
    check("rst_reach_index4", index_a, 4);
    check("rst_reach_data104", data_a, 104);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("mid_rst");
    n_valid = 0;
    n_done  = 0;
    repeat (10) begin
      tick();
      if (valid_a) n_valid++;
      if (done_a) n_done++;
    end
    check("after_rst_no_valid", n_valid, 0);
    check("after_rst_no_done", n_done, 0);
    is_completed = 1'b0;
    tick();
    tick();
    stream_full(1'b0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/fir_result_streamer.md
FIR_RESULT_STREAMER -- requirements
Module: fir_result_streamer

Interface
REQ-001 Parameter LEN, default 19, filter order; the filter has LEN+1 taps.
REQ-002 Parameter SIGNAL_LENGTH_1, default 2400, index of the last input signal sample.
REQ-003 Parameter DROP_HEAD, default 0, number of leading result samples discarded; range 0..TOTAL-1.
REQ-004 Derived constant TOTAL = LEN+SIGNAL_LENGTH_1+1, the number of result samples.
REQ-005 clk  input  1  single clock; all logic on posedge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 flatten_conv_result  input  TOTAL*16+1  signed packed results; sample k is in bits [k*16 +: 16]; the MSB is unused.
REQ-008 is_completed  input  1  level from the convolver; high means the results are valid.
REQ-009 sample_data  output  16  signed result sample.
REQ-010 sample_valid  output  1  sample_data is valid.
REQ-011 sample_ready  input  1  downstream accepts the sample.
REQ-012 sample_index  output  12  index k of the current sample (TOTAL-1 fits in 12 bits for defaults).
REQ-013 sample_last  output  1  high with the sample at k = TOTAL-1.
REQ-014 busy  output  1  high in CAPTURE or STREAM.
REQ-015 done  output  1  one-cycle pulse after the last transfer.

Function
REQ-016 The FSM SHALL have the states IDLE, CAPTURE, STREAM and WAIT_LOW.
REQ-017 In IDLE, a rising edge of is_completed (high now, low last cycle) SHALL move the FSM to CAPTURE.
- A level already high when reset releases SHALL NOT trigger.
REQ-018 CAPTURE SHALL last one cycle.
- It registers the whole flatten_conv_result into an internal buffer.
- It loads the index counter with DROP_HEAD.
- It then moves to STREAM.
REQ-019 In STREAM, sample_valid SHALL be 1 and sample_data SHALL equal buffer[index*16 +: 16].
- The first valid sample appears 2 cycles after the is_completed rising edge.
REQ-020 A transfer SHALL occur when sample_valid and sample_ready are both high in the same cycle.
- On a transfer the index increments.
- With sample_ready held high, the block delivers one sample per cycle.
REQ-021 While sample_ready is low, sample_data, sample_index and sample_last SHALL hold stable.
- sample_valid stays high; valid is never withdrawn before a transfer.
REQ-022 A transfer with sample_last = 1 SHALL:
- move the FSM to WAIT_LOW;
- drop sample_valid in the next cycle;
- pulse done for exactly one cycle, in the cycle after that transfer.
REQ-023 WAIT_LOW SHALL return to IDLE once is_completed is sampled low, so each completion streams exactly once.
REQ-024 Changes on flatten_conv_result after CAPTURE SHALL NOT affect the streamed data.
REQ-025 Samples SHALL be passed bit-exact, with no rescaling or saturation.
REQ-026 When DROP_HEAD = TOTAL-1, exactly one sample is streamed, and it carries sample_last = 1.
REQ-027 The index counter SHALL NOT wrap; it stops at TOTAL-1.

Reset
REQ-028 rst SHALL force, on the next posedge:
- FSM = IDLE;
- sample_valid = 0, sample_last = 0, busy = 0, done = 0;
- sample_index = 0, sample_data = 0;
- edge-detect register = 1, so a stale high level is ignored.
REQ-029 rst asserted during STREAM SHALL abort the stream with no done pulse.
- After rst, a new rising edge of is_completed is required to start again.
REQ-030 The capture buffer SHALL NOT require reset.

Structure
REQ-031 A shared package fir_pkg SHALL hold:
- the default values of LEN and SIGNAL_LENGTH_1;
- the sample width 16;
- the FSM state encoding.
REQ-032 One sub-module, fir_sample_mux, SHALL select a 16-bit slice by index.
- It is registered, with 0 added latency relative to REQ-019 because it is fed from the next-index value.
- All other logic stays flat in fir_result_streamer.

Verification
REQ-033 LEN=3, SIGNAL_LENGTH_1=4 (TOTAL=8), sample k = 100+k, sample_ready held at 1, is_completed rises at cycle 10:
- valid samples 100..107 appear in cycles 12..19;
- sample_last is high in cycle 19;
- done is high in cycle 20.
REQ-034 Same setup, sample_ready toggled 1,0,0,1,...:
- every sample is delivered once, in order;
- data holds stable during stalls;
- done follows the transfer of sample 107.
REQ-035 DROP_HEAD=3:
- the stream is 103..107 with sample_index 3..7;
- sample_last is high on 107.
REQ-036 is_completed held high for 50 cycles after streaming finishes: exactly one stream and one done pulse occur.
- After is_completed goes low then high again, a second stream occurs.
REQ-037 rst pulsed while index = 4:
- all outputs return to their reset values the next cycle;
- there is no done pulse;
- a new rising edge restarts streaming from sample 100.
REQ-038 flatten_conv_result rewritten to all 0xFFFF during STREAM: the original values 100..107 are still streamed.
